// File: rtl/issue_scheduler_pkg.sv
// Shared types and sizing for the reservation-station issue scheduler.
// Grant ports carry {valid, idx} per functional unit, indexed by fu_id_e.
package issue_scheduler_pkg;

  localparam int RS_ENTRIES = 16;
  localparam int N_ENTRIES  = RS_ENTRIES;
  localparam int IDX_W      = $clog2(N_ENTRIES);
  localparam int N_ALLOC    = 2;
  localparam int N_FU       = 3;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MEM  = 2'd2
  } fu_id_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } issue_grant_struct;

  // Encoder for a one-hot (or empty) vector; empty yields index 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_ENTRIES-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (oh[i]) r = r | IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/age_oldest_select.sv
// Picks the oldest requester: an entry wins when no other requester is older
// according to the age matrix (age[j][i] = 1 means j is older than i).
module age_oldest_select
  import issue_scheduler_pkg::*;
#(
  parameter int N = RS_ENTRIES
) (
  input  logic [N-1:0][N-1:0] age,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        oldest
);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic [N-1:0] older;
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign older[gj] = req[gj] & age[gj][gi];
    end
    assign oldest[gi] = req[gi] & ~(|older);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Reservation-station select: up to two ALU grants and one MEM grant per cycle,
// oldest first, with an age matrix maintained on allocation. Grants are registered.
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc_valid [0:N_ALLOC-1],
  input  logic [IDX_W-1:0]       alloc_idx   [0:N_ALLOC-1],
  input  logic [N_ENTRIES-1:0]   ready_vec,
  input  logic [N_ENTRIES-1:0]   is_mem_vec,
  input  logic [N_FU-1:0]        fu_ready,
  output issue_grant_struct      issue_grant [0:N_FU-1],
  output logic [N_ENTRIES-1:0]   issue_clear
);

  logic [N_ENTRIES-1:0][N_ENTRIES-1:0] age_reg, age_next;
  logic [N_ENTRIES-1:0] valid_reg, valid_next;
  logic [N_ENTRIES-1:0] issued_reg, issued_next;
  logic [N_ENTRIES-1:0] clear_reg, clear_next;
  issue_grant_struct    grant_reg  [0:N_FU-1];
  issue_grant_struct    grant_next [0:N_FU-1];

  logic [N_ENTRIES-1:0] cand, alu_req, mem_req, alu_rest;
  logic [N_ENTRIES-1:0] alu_first, alu_second, mem_first;
  logic [N_ENTRIES-1:0] grant_oh [0:N_FU-1];
  logic [N_ENTRIES-1:0] live;

  assign cand     = ready_vec & ~issued_reg & valid_reg;
  assign alu_req  = cand & ~is_mem_vec;
  assign mem_req  = cand & is_mem_vec;
  assign alu_rest = alu_req & ~alu_first;
  assign live     = valid_reg & ~issued_reg;

  age_oldest_select #(.N(N_ENTRIES)) u_sel_mem (
    .age    (age_reg),
    .req    (mem_req),
    .oldest (mem_first)
  );

  age_oldest_select #(.N(N_ENTRIES)) u_sel_alu (
    .age    (age_reg),
    .req    (alu_req),
    .oldest (alu_first)
  );

  age_oldest_select #(.N(N_ENTRIES)) u_sel_alu2 (
    .age    (age_reg),
    .req    (alu_rest),
    .oldest (alu_second)
  );

  // FU1 takes the oldest ALU op when FU0 is busy, otherwise the runner-up.
  always_comb begin
    grant_oh[FU_ALU0] = fu_ready[FU_ALU0] ? alu_first : '0;
    grant_oh[FU_ALU1] = '0;
    if (fu_ready[FU_ALU1]) begin
      grant_oh[FU_ALU1] = fu_ready[FU_ALU0] ? alu_second : alu_first;
    end
    grant_oh[FU_MEM]  = fu_ready[FU_MEM] ? mem_first : '0;
  end

  always_comb begin
    clear_next = '0;
    for (int f = 0; f < N_FU; f++) begin
      grant_next[f].valid = |grant_oh[f];
      grant_next[f].idx   = onehot_to_idx(grant_oh[f]);
      clear_next          = clear_next | grant_oh[f];
    end
    if (flush) begin
      clear_next = '0;
      for (int f = 0; f < N_FU; f++) begin
        grant_next[f] = '0;
      end
    end
  end

  // Slot 0 is applied first so slot 1 sees it as valid and lands younger.
  always_comb begin
    age_next    = age_reg;
    valid_next  = valid_reg;
    issued_next = issued_reg | clear_next;
    for (int k = 0; k < N_ALLOC; k++) begin
      if (alloc_valid[k]) begin
        age_next[alloc_idx[k]] = '0;
        for (int j = 0; j < N_ENTRIES; j++) begin
          age_next[j][alloc_idx[k]] = (IDX_W'(j) != alloc_idx[k]) && valid_next[j];
        end
        valid_next[alloc_idx[k]]  = 1'b1;
        issued_next[alloc_idx[k]] = 1'b0;
      end
    end
    if (flush) begin
      age_next    = age_reg;
      valid_next  = '0;
      issued_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_reg    <= '0;
      valid_reg  <= '0;
      issued_reg <= '0;
      clear_reg  <= '0;
      for (int f = 0; f < N_FU; f++) begin
        grant_reg[f] <= '0;
      end
    end else begin
      age_reg    <= age_next;
      valid_reg  <= valid_next;
      issued_reg <= issued_next;
      clear_reg  <= clear_next;
      for (int f = 0; f < N_FU; f++) begin
        grant_reg[f] <= grant_next[f];
      end
    end
  end

  assign issue_grant = grant_reg;
  assign issue_clear = clear_reg;

  for (genvar gi = 0; gi < N_ALLOC; gi++) begin : g_alloc_chk
    a_alloc_free: assert property (@(posedge clk) disable iff (rst)
      (alloc_valid[gi] && !flush) |-> !live[alloc_idx[gi]]);
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: stimulus pushes model predictions,
// a monitor pops and compares each registered output vector.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 alloc_valid [0:1];
  logic [3:0]           alloc_idx   [0:1];
  logic [15:0]          ready_vec = '0;
  logic [15:0]          is_mem_vec = '0;
  logic [2:0]           fu_ready = '0;
  issue_grant_struct    grant [0:2];
  logic [15:0]          issue_clear;

  typedef struct packed {
    logic [2:0]      v;
    logic [2:0][3:0] idx;
    logic [15:0]     clr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: tracked entries in allocation order, oldest first.
  int   order[$];
  bit   issued[16];

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx),
    .ready_vec   (ready_vec),
    .is_mem_vec  (is_mem_vec),
    .fu_ready    (fu_ready),
    .issue_grant (grant),
    .issue_clear (issue_clear)
  );

  function automatic exp_t actual();
    exp_t a;
    a = '0;
    for (int k = 0; k < 3; k++) begin
      a.v[k]   = grant[k].valid;
      a.idx[k] = grant[k].idx;
    end
    a.clr = issue_clear;
    return a;
  endfunction

  function automatic bit in_order(input int idx);
    foreach (order[q]) if (order[q] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit can_alloc(input int idx);
    return !(in_order(idx) && !issued[idx]);
  endfunction

  task automatic model_clear();
    order.delete();
    for (int i = 0; i < 16; i++) issued[i] = 1'b0;
  endtask

  task automatic model_alloc(input int idx);
    for (int q = 0; q < order.size(); q++) begin
      if (order[q] == idx) begin
        order.delete(q);
        break;
      end
    end
    order.push_back(idx);
    issued[idx] = 1'b0;
  endtask

  task automatic step(input bit r, input bit fl, input bit a0v, input int a0,
                      input bit a1v, input int a1, input logic [15:0] rdy,
                      input logic [15:0] mm, input logic [2:0] fu);
    exp_t e;
    int   alu[$];
    int   memq[$];
    int   g[3];
    bit   gv[3];
    @(negedge clk);
    rst            = r;
    flush          = fl;
    alloc_valid[0] = a0v;
    alloc_idx[0]   = 4'(a0);
    alloc_valid[1] = a1v;
    alloc_idx[1]   = 4'(a1);
    ready_vec      = rdy;
    is_mem_vec     = mm;
    fu_ready       = fu;
    e = '0;
    if (r) begin
      model_clear();
      #1;
      vectors++;
      if (actual() !== '0) begin
        miscompares++;
        $display("FAIL reset_async: got %h, want 0", actual());
      end
    end else if (fl) begin
      model_clear();
    end else begin
      for (int k = 0; k < 3; k++) begin
        gv[k] = 1'b0;
        g[k]  = 0;
      end
      foreach (order[q]) begin
        if (rdy[order[q]] && !issued[order[q]]) begin
          if (mm[order[q]]) memq.push_back(order[q]);
          else alu.push_back(order[q]);
        end
      end
      if (fu[0] && alu.size() > 0) begin gv[0] = 1'b1; g[0] = alu[0]; end
      if (fu[1]) begin
        if (fu[0]) begin
          if (alu.size() > 1) begin gv[1] = 1'b1; g[1] = alu[1]; end
        end else if (alu.size() > 0) begin
          gv[1] = 1'b1; g[1] = alu[0];
        end
      end
      if (fu[2] && memq.size() > 0) begin gv[2] = 1'b1; g[2] = memq[0]; end
      for (int k = 0; k < 3; k++) begin
        if (gv[k]) begin
          e.v[k]      = 1'b1;
          e.idx[k]    = 4'(g[k]);
          e.clr[g[k]] = 1'b1;
          issued[g[k]] = 1'b1;
        end
      end
      if (a0v) model_alloc(a0);
      if (a1v) model_alloc(a1);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [15:0] rdy, input logic [15:0] mm, input logic [2:0] fu);
    step(0, 0, 0, 0, 0, 0, rdy, mm, fu);
  endtask

  // Monitor: one registered output vector per cycle, checked against the queue.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL grant_vec: got v=%b idx=%h clr=%h, want v=%b idx=%h clr=%h",
                   a.v, a.idx, a.clr, e.v, e.idx, e.clr);
        end else begin
          $display("vec %0d: v=%b idx=%h clr=%h", vectors, a.v, a.idx, a.clr);
        end
      end
    end
  end

  initial begin
    bit          r, fl, a0v, a1v;
    int          a0, a1;
    logic [15:0] rdy, mm;
    alloc_valid[0] = 1'b0;
    alloc_valid[1] = 1'b0;
    alloc_idx[0]   = '0;
    alloc_idx[1]   = '0;
    model_clear();

    step(1, 0, 0, 0, 0, 0, '0, '0, 3'b000);
    step(1, 0, 0, 0, 0, 0, '0, '0, 3'b000);

    // Two ALU entries allocated on separate cycles, both FUs free.
    step(0, 0, 1, 3, 0, 0, '0, '0, 3'b111);
    step(0, 0, 1, 7, 0, 0, '0, '0, 3'b111);
    idle(16'h0088, 16'h0000, 3'b111);
    idle(16'h0088, 16'h0000, 3'b111);

    // Same-cycle pair, only FU1 available.
    step(0, 0, 1, 5, 1, 2, '0, '0, 3'b000);
    idle(16'h0024, 16'h0000, 3'b010);
    idle(16'h0024, 16'h0000, 3'b010);
    idle(16'h0024, 16'h0000, 3'b010);

    // MEM pair with FU2 ready toggling.
    step(0, 0, 1, 1, 1, 4, '0, '0, 3'b000);
    idle(16'h0012, 16'h0012, 3'b000);
    idle(16'h0012, 16'h0012, 3'b100);
    idle(16'h0012, 16'h0012, 3'b100);

    // Flush beats same-cycle allocation.
    step(0, 1, 1, 9, 0, 0, 16'h0200, '0, 3'b111);
    idle(16'h0200, 16'h0000, 3'b111);
    idle(16'hFFFF, 16'h0000, 3'b111);

    // Re-allocated entry becomes youngest.
    step(0, 1, 0, 0, 0, 0, '0, '0, 3'b000);
    step(0, 0, 1, 6, 0, 0, '0, '0, 3'b000);
    step(0, 0, 1, 0, 0, 0, 16'h0040, '0, 3'b001);
    step(0, 0, 1, 6, 0, 0, '0, '0, 3'b000);
    idle(16'h0041, 16'h0000, 3'b001);
    idle(16'h0041, 16'h0000, 3'b001);
    idle(16'h0041, 16'h0000, 3'b001);

    // Reset while grants are pending, then nothing until re-allocation.
    step(0, 0, 1, 10, 1, 11, '0, '0, 3'b000);
    idle(16'h0C00, 16'h0000, 3'b111);
    step(1, 0, 0, 0, 0, 0, 16'h0C00, '0, 3'b111);
    idle(16'hFFFF, 16'h0000, 3'b111);
    step(0, 0, 1, 10, 0, 0, 16'hFFFF, '0, 3'b111);
    idle(16'hFFFF, 16'h0000, 3'b111);

    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 299) == 0);
      fl  = ($urandom_range(0, 49) == 0);
      a0v = 1'($urandom_range(0, 1));
      a1v = 1'($urandom_range(0, 1));
      a0  = $urandom_range(0, 15);
      a1  = $urandom_range(0, 15);
      if (a0v && !can_alloc(a0)) a0v = 1'b0;
      if (a1v && (!can_alloc(a1) || (a0v && a1 == a0))) a1v = 1'b0;
      rdy = 16'($urandom) | 16'($urandom);
      mm  = 16'($urandom);
      step(r, fl, a0v, a0, a1v, a1, rdy, mm, 3'($urandom));
      if (r) step(1, 0, 0, 0, 0, 0, '0, '0, 3'b000);
    end

    idle('0, '0, 3'b000);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
